// File: rtl/bomb_slot_sched.sv
// Shared bomb-slot pool for two players: round-robin placement into fuse-timed
// slots, force-detonation, and valid/ready serialization of expired bombs.
module bomb_slot_sched #(
  parameter int SLOTS = 8,
  parameter int FUSE  = 90
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         p1_put,
  input  logic         p2_put,
  input  logic [7:0]   p1_cor,
  input  logic [7:0]   p2_cor,
  input  logic [1:0]   p1_len,
  input  logic [1:0]   p2_len,
  input  logic [2:0]   p1_cap,
  input  logic [2:0]   p2_cap,
  input  logic         det_req,
  input  logic [7:0]   det_cor,
  input  logic         ex_ready,
  output logic         ex_valid,
  output logic [7:0]   ex_cor,
  output logic [1:0]   ex_len,
  output logic         ex_owner,
  output logic         p1_ack,
  output logic         p2_ack,
  output logic         p1_nack,
  output logic         p2_nack,
  output logic [2:0]   p1_num,
  output logic [2:0]   p2_num,
  output logic [255:0] occ
);
  localparam int FW = $clog2(FUSE + 1);
  localparam int IW = $clog2(SLOTS);

  logic [SLOTS-1:0]         valid_q, valid_d;
  logic [SLOTS-1:0]         owner_q, owner_d;
  logic [SLOTS-1:0]         exp_q, exp_d;
  logic [SLOTS-1:0][7:0]    cor_q, cor_d;
  logic [SLOTS-1:0][1:0]    len_q, len_d;
  logic [SLOTS-1:0][FW-1:0] fuse_q, fuse_d;
  logic [255:0]             occ_q, occ_d;
  logic [2:0]               num1_q, num1_d, num2_q, num2_d;
  logic                     prio_q, prio_d;
  logic [1:0]               ack_q, ack_d, nack_q, nack_d;

  logic                     ex_valid_s, hs_s, ret1_s, ret2_s;
  logic [IW-1:0]            ex_idx_s, slot_s;
  logic [SLOTS-1:0]         free_s;
  logic [255:0]             occ_t_s;
  logic                     pl_s, req_s, ok_s;
  logic [7:0]               cor_s;
  logic [1:0]               len_s;
  logic [2:0]               cap_s, num_s;
  logic [1:0]               acc_s;

  // Lowest-index expired slot is the one presented to the explosion logic.
  always_comb begin
    ex_valid_s = |(valid_q & exp_q);
    ex_idx_s   = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      ex_idx_s = (valid_q[s] && exp_q[s]) ? IW'(s) : ex_idx_s;
    end
    hs_s   = ex_valid_s & ex_ready;
    ret1_s = hs_s & ~owner_q[ex_idx_s];
    ret2_s = hs_s & owner_q[ex_idx_s];
  end

  // Slot table next state: fuse/detonation, retirement, then the two placements.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    exp_d   = exp_q;
    cor_d   = cor_q;
    len_d   = len_q;
    fuse_d  = fuse_q;
    nack_d  = 2'b00;
    acc_s   = 2'b00;
    for (int s = 0; s < SLOTS; s++) begin
      if (valid_q[s] && !exp_q[s] && det_req && (cor_q[s] == det_cor)) begin
        fuse_d[s] = '0;
        exp_d[s]  = 1'b1;
      end else if (valid_q[s] && !exp_q[s] && tick && (fuse_q[s] != '0)) begin
        fuse_d[s] = fuse_q[s] - FW'(1);
        exp_d[s]  = (fuse_q[s] == FW'(1));
      end else begin
        fuse_d[s] = fuse_q[s];
      end
    end
    valid_d[ex_idx_s] = valid_d[ex_idx_s] & ~hs_s;
    exp_d[ex_idx_s]   = exp_d[ex_idx_s] & ~hs_s;

    // Freed slots stay unavailable this cycle: free/occ come from registered state.
    free_s  = ~valid_q;
    occ_t_s = occ_q;
    pl_s    = 1'b0;
    req_s   = 1'b0;
    cor_s   = 8'h00;
    len_s   = 2'b00;
    cap_s   = 3'd0;
    num_s   = 3'd0;
    slot_s  = '0;
    ok_s    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pl_s  = prio_q ^ 1'(k);
      req_s = pl_s ? p2_put : p1_put;
      cor_s = pl_s ? p2_cor : p1_cor;
      len_s = pl_s ? p2_len : p1_len;
      cap_s = pl_s ? p2_cap : p1_cap;
      num_s = pl_s ? num2_q : num1_q;
      slot_s = '0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
        slot_s = free_s[s] ? IW'(s) : slot_s;
      end
      ok_s = req_s && (num_s < cap_s) && (|free_s) && !occ_t_s[cor_s];
      if (ok_s) begin
        valid_d[slot_s] = 1'b1;
        owner_d[slot_s] = pl_s;
        cor_d[slot_s]   = cor_s;
        len_d[slot_s]   = len_s;
        fuse_d[slot_s]  = FW'(FUSE);
        exp_d[slot_s]   = 1'b0;
        free_s[slot_s]  = 1'b0;
        occ_t_s[cor_s]  = 1'b1;
        acc_s[pl_s]     = 1'b1;
      end else begin
        nack_d[pl_s] = req_s;
      end
    end
    ack_d  = acc_s;
    prio_d = (p1_put & p2_put) ? ~prio_q : prio_q;
    num1_d = num1_q + {2'b00, acc_s[0]} - {2'b00, ret1_s};
    num2_d = num2_q + {2'b00, acc_s[1]} - {2'b00, ret2_s};
    occ_d  = '0;
    for (int s = 0; s < SLOTS; s++) begin
      occ_d[cor_d[s]] = occ_d[cor_d[s]] | valid_d[s];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
      exp_q   <= '0;
      cor_q   <= '0;
      len_q   <= '0;
      fuse_q  <= '0;
      occ_q   <= '0;
      num1_q  <= 3'd0;
      num2_q  <= 3'd0;
      prio_q  <= 1'b0;
      ack_q   <= 2'b00;
      nack_q  <= 2'b00;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      exp_q   <= exp_d;
      cor_q   <= cor_d;
      len_q   <= len_d;
      fuse_q  <= fuse_d;
      occ_q   <= occ_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      prio_q  <= prio_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
    end
  end

  assign ex_valid = ex_valid_s;
  assign ex_cor   = ex_valid_s ? cor_q[ex_idx_s] : 8'h00;
  assign ex_len   = ex_valid_s ? len_q[ex_idx_s] : 2'b00;
  assign ex_owner = ex_valid_s ? owner_q[ex_idx_s] : 1'b0;
  assign p1_ack   = ack_q[0];
  assign p2_ack   = ack_q[1];
  assign p1_nack  = nack_q[0];
  assign p2_nack  = nack_q[1];
  assign p1_num   = num1_q;
  assign p2_num   = num2_q;
  assign occ      = occ_q;
endmodule

// File: tb/tb_bomb_slot_sched.sv
// Bench for bomb_slot_sched: placement vector table, hand-written fuse/backpressure/
// chain/reset sequences, then random traffic against a slot-list reference model.
module tb_bomb_slot_sched;
  localparam int SLOTS = 8;
  localparam int FUSE  = 90;

  logic clk = 1'b0;
  logic rst, tick, p1_put, p2_put, det_req, ex_ready;
  logic [7:0] p1_cor, p2_cor, det_cor;
  logic [1:0] p1_len, p2_len;
  logic [2:0] p1_cap, p2_cap;
  logic ex_valid, ex_owner, p1_ack, p2_ack, p1_nack, p2_nack;
  logic [7:0] ex_cor;
  logic [1:0] ex_len;
  logic [2:0] p1_num, p2_num;
  logic [255:0] occ;

  int errors = 0;
  int checks = 0;

  bomb_slot_sched #(.SLOTS(SLOTS), .FUSE(FUSE)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .p1_put(p1_put), .p2_put(p2_put), .p1_cor(p1_cor), .p2_cor(p2_cor),
    .p1_len(p1_len), .p2_len(p2_len), .p1_cap(p1_cap), .p2_cap(p2_cap),
    .det_req(det_req), .det_cor(det_cor), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_cor(ex_cor), .ex_len(ex_len), .ex_owner(ex_owner),
    .p1_ack(p1_ack), .p2_ack(p2_ack), .p1_nack(p1_nack), .p2_nack(p2_nack),
    .p1_num(p1_num), .p2_num(p2_num), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; tick = 1'b0; p1_put = 1'b0; p2_put = 1'b0;
    p1_cor = 8'h00; p2_cor = 8'h00; p1_len = 2'd0; p2_len = 2'd0;
    p1_cap = 3'd0; p2_cap = 3'd0; det_req = 1'b0; det_cor = 8'h00; ex_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Reference model: a plain list of bombs indexed by slot number.
  bit         m_valid[SLOTS];
  bit         m_owner[SLOTS];
  bit         m_exp[SLOTS];
  logic [7:0] m_cor[SLOTS];
  logic [1:0] m_len[SLOTS];
  int         m_fuse[SLOTS];
  bit         m_prio;
  bit         e_ack[2];
  bit         e_nack[2];

  function automatic int m_lowest_expired();
    for (int s = 0; s < SLOTS; s++) if (m_valid[s] && m_exp[s]) return s;
    return -1;
  endfunction

  function automatic bit m_holds(input logic [7:0] c);
    for (int s = 0; s < SLOTS; s++) if (m_valid[s] && m_cor[s] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_count(input bit o);
    int n = 0;
    for (int s = 0; s < SLOTS; s++) if (m_valid[s] && m_owner[s] == o) n++;
    return n;
  endfunction

  task automatic model_edge();
    int xi, taken, fr, p;
    int slot[2];
    int order[2];
    bit put[2];
    logic [7:0] pc[2];
    logic [1:0] pln[2];
    int cap[2];
    bit won;
    logic [7:0] won_cor;
    put[0] = p1_put; put[1] = p2_put;
    pc[0] = p1_cor;  pc[1] = p2_cor;
    pln[0] = p1_len; pln[1] = p2_len;
    cap[0] = int'(p1_cap); cap[1] = int'(p2_cap);
    e_ack[0] = 0; e_ack[1] = 0; e_nack[0] = 0; e_nack[1] = 0;
    if (rst) begin
      for (int s = 0; s < SLOTS; s++) begin
        m_valid[s] = 0; m_exp[s] = 0;
      end
      m_prio = 0;
      return;
    end
    xi = m_lowest_expired();
    won = 0; won_cor = 8'h00; taken = -1; slot[0] = -1; slot[1] = -1;
    order[0] = m_prio ? 1 : 0;
    order[1] = 1 - order[0];
    for (int k = 0; k < 2; k++) begin
      p = order[k];
      if (put[p]) begin
        fr = -1;
        for (int s = 0; s < SLOTS; s++) if (!m_valid[s] && s != taken && fr < 0) fr = s;
        if (m_count(1'(p)) < cap[p] && fr >= 0 && !m_holds(pc[p]) && !(won && won_cor == pc[p])) begin
          e_ack[p] = 1; slot[p] = fr; taken = fr; won = 1; won_cor = pc[p];
        end else begin
          e_nack[p] = 1;
        end
      end
    end
    if (put[0] && put[1]) m_prio = ~m_prio;
    for (int s = 0; s < SLOTS; s++) begin
      if (m_valid[s] && !m_exp[s]) begin
        if (det_req && m_cor[s] == det_cor) begin
          m_fuse[s] = 0; m_exp[s] = 1;
        end else if (tick && m_fuse[s] > 0) begin
          m_fuse[s]--;
          if (m_fuse[s] == 0) m_exp[s] = 1;
        end
      end
    end
    if (xi >= 0 && ex_ready) begin
      m_valid[xi] = 0; m_exp[xi] = 0;
    end
    for (int q = 0; q < 2; q++) begin
      if (slot[q] >= 0) begin
        m_valid[slot[q]] = 1; m_owner[slot[q]] = 1'(q); m_cor[slot[q]] = pc[q];
        m_len[slot[q]] = pln[q]; m_fuse[slot[q]] = FUSE; m_exp[slot[q]] = 0;
      end
    end
  endtask

  task automatic check_model();
    int xi;
    logic [255:0] occ_e;
    xi = m_lowest_expired();
    occ_e = '0;
    for (int s = 0; s < SLOTS; s++) if (m_valid[s]) occ_e[m_cor[s]] = 1'b1;
    chk("rnd ex_valid", ex_valid, (xi >= 0));
    if (xi >= 0) begin
      chk("rnd ex_cor", ex_cor, m_cor[xi]);
      chk("rnd ex_len", ex_len, m_len[xi]);
      chk("rnd ex_owner", ex_owner, m_owner[xi]);
    end else begin
      chk("rnd ex_idle", {ex_cor, ex_len, ex_owner}, 11'd0);
    end
    chk("rnd p1_ack", p1_ack, e_ack[0]);
    chk("rnd p2_ack", p2_ack, e_ack[1]);
    chk("rnd p1_nack", p1_nack, e_nack[0]);
    chk("rnd p2_nack", p2_nack, e_nack[1]);
    chk("rnd p1_num", p1_num, m_count(1'b0));
    chk("rnd p2_num", p2_num, m_count(1'b1));
    chk("rnd occ", occ, occ_e);
  endtask

  typedef struct {
    logic       p1_put;
    logic [7:0] p1_cor;
    logic [2:0] p1_cap;
    logic       p2_put;
    logic [7:0] p2_cor;
    logic [2:0] p2_cap;
    logic [3:0] exp_an;
    logic [2:0] exp_n1;
    logic [2:0] exp_n2;
    logic       exp_occ1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // exp_an = {p1_ack, p1_nack, p2_ack, p2_nack}
    vecs[0] = '{1'b1, 8'h01, 3'd2, 1'b0, 8'h00, 3'd0, 4'b1000, 3'd1, 3'd0, 1'b1};
    vecs[1] = '{1'b1, 8'h02, 3'd2, 1'b0, 8'h00, 3'd0, 4'b1000, 3'd2, 3'd0, 1'b1};
    vecs[2] = '{1'b1, 8'h03, 3'd2, 1'b0, 8'h00, 3'd0, 4'b0100, 3'd2, 3'd0, 1'b0};
    vecs[3] = '{1'b1, 8'h22, 3'd3, 1'b1, 8'h22, 3'd2, 4'b1001, 3'd3, 3'd0, 1'b1};
    vecs[4] = '{1'b1, 8'h33, 3'd4, 1'b1, 8'h33, 3'd2, 4'b0110, 3'd3, 3'd1, 1'b1};
    vecs[5] = '{1'b0, 8'h02, 3'd7, 1'b1, 8'h05, 3'd0, 4'b0001, 3'd3, 3'd1, 1'b1};
    vecs[6] = '{1'b1, 8'h01, 3'd7, 1'b0, 8'h00, 3'd0, 4'b0100, 3'd3, 3'd1, 1'b1};
    vecs[7] = '{1'b1, 8'h06, 3'd7, 1'b1, 8'h07, 3'd7, 4'b1010, 3'd4, 3'd2, 1'b1};
    vecs[8] = '{1'b1, 8'h08, 3'd7, 1'b1, 8'h09, 3'd7, 4'b1010, 3'd5, 3'd3, 1'b1};
    vecs[9] = '{1'b1, 8'h0A, 3'd7, 1'b0, 8'h00, 3'd0, 4'b0100, 3'd5, 3'd3, 1'b0};

    // Reset state
    do_reset();
    chk("reset ex_valid", ex_valid, 1'b0);
    chk("reset ex_fields", {ex_cor, ex_len, ex_owner}, 11'd0);
    chk("reset acks", {p1_ack, p1_nack, p2_ack, p2_nack}, 4'b0000);
    chk("reset nums", {p1_num, p2_num}, 6'd0);
    chk("reset occ", occ, 256'd0);

    // Placement table: caps, collisions, round-robin priority, full pool
    for (int i = 0; i < 10; i++) begin
      idle();
      p1_put = vecs[i].p1_put; p1_cor = vecs[i].p1_cor; p1_cap = vecs[i].p1_cap;
      p2_put = vecs[i].p2_put; p2_cor = vecs[i].p2_cor; p2_cap = vecs[i].p2_cap;
      step();
      chk($sformatf("vec%0d acks", i), {p1_ack, p1_nack, p2_ack, p2_nack}, vecs[i].exp_an);
      chk($sformatf("vec%0d p1_num", i), p1_num, vecs[i].exp_n1);
      chk($sformatf("vec%0d p2_num", i), p2_num, vecs[i].exp_n2);
      chk($sformatf("vec%0d occ", i), occ[vecs[i].p1_cor], vecs[i].exp_occ1);
    end
    idle();
    step();
    chk("ack one-cycle", {p1_ack, p1_nack, p2_ack, p2_nack}, 4'b0000);

    // Full fuse run and retirement
    do_reset();
    tick = 1'b1; p1_put = 1'b1; p1_cor = 8'h11; p1_len = 2'd1; p1_cap = 3'd1;
    step();
    p1_put = 1'b0;
    chk("fuse ack", p1_ack, 1'b1);
    chk("fuse occ", occ[8'h11], 1'b1);
    chk("fuse num", p1_num, 3'd1);
    for (int i = 0; i < FUSE - 1; i++) step();
    chk("fuse early", ex_valid, 1'b0);
    step();
    chk("fuse ex_valid", ex_valid, 1'b1);
    chk("fuse ex_fields", {ex_cor, ex_len, ex_owner}, {8'h11, 2'd1, 1'b0});
    ex_ready = 1'b1;
    step();
    chk("retire num", p1_num, 3'd0);
    chk("retire occ", occ[8'h11], 1'b0);
    chk("retire ex_valid", ex_valid, 1'b0);

    // Backpressure with two bombs expiring together
    do_reset();
    tick = 1'b1;
    p1_put = 1'b1; p1_cor = 8'h50; p1_len = 2'd2; p1_cap = 3'd1;
    p2_put = 1'b1; p2_cor = 8'h51; p2_len = 2'd3; p2_cap = 3'd1;
    step();
    p1_put = 1'b0; p2_put = 1'b0;
    chk("bp acks", {p1_ack, p2_ack}, 2'b11);
    for (int i = 0; i < FUSE; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp hold", {ex_valid, ex_cor, ex_len, ex_owner}, {1'b1, 8'h50, 2'd2, 1'b0});
      step();
    end
    ex_ready = 1'b1; p1_put = 1'b1; p1_cor = 8'h50; p1_cap = 3'd2;
    step();
    p1_put = 1'b0;
    chk("bp put on retiring cor", {p1_ack, p1_nack}, 2'b01);
    chk("bp beat2", {ex_valid, ex_cor, ex_len, ex_owner}, {1'b1, 8'h51, 2'd3, 1'b1});
    chk("bp num after beat1", {p1_num, p2_num}, {3'd0, 3'd1});
    step();
    chk("bp drained", ex_valid, 1'b0);
    chk("bp occ", occ, 256'd0);

    // Chain detonation
    do_reset();
    tick = 1'b1; p1_put = 1'b1; p1_cor = 8'h44; p1_len = 2'd0; p1_cap = 3'd1;
    step();
    p1_put = 1'b0;
    for (int i = 0; i < 5; i++) step();
    det_req = 1'b1; det_cor = 8'h45;
    step();
    det_req = 1'b0;
    chk("det miss", {ex_valid, p1_num, occ[8'h44]}, {1'b0, 3'd1, 1'b1});
    for (int i = 0; i < 4; i++) step();
    det_req = 1'b1; det_cor = 8'h44;
    step();
    det_req = 1'b0;
    chk("det hit", {ex_valid, ex_cor}, {1'b1, 8'h44});

    // Reset mid-handshake
    ex_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst mid ex", {ex_valid, ex_cor, ex_len, ex_owner}, 12'd0);
    chk("rst mid occ", occ, 256'd0);
    chk("rst mid nums", {p1_num, p2_num}, 6'd0);
    p2_put = 1'b1; p2_cor = 8'h77; p2_cap = 3'd1;
    step();
    p2_put = 1'b0;
    chk("rst fresh put", {p2_ack, p2_num, occ[8'h77]}, {1'b1, 3'd1, 1'b1});

    // Random traffic against the model
    idle();
    rst = 1'b1;
    model_edge();
    step();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 399) == 0);
      tick    = ($urandom_range(0, 3) != 0);
      p1_put  = ($urandom_range(0, 2) == 0);
      p2_put  = ($urandom_range(0, 2) == 0);
      p1_cor  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      p2_cor  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      p1_len  = 2'($urandom_range(0, 3));
      p2_len  = 2'($urandom_range(0, 3));
      p1_cap  = 3'($urandom_range(0, 5));
      p2_cap  = 3'($urandom_range(0, 5));
      det_req = ($urandom_range(0, 5) == 0);
      det_cor = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      ex_ready = ($urandom_range(0, 1) == 0);
      model_edge();
      step();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
